// File: rtl/timing_engine_fanout.sv
// Radio power-up timing engine: waits for PLL lock, enables the masked
// channels together, then staggers each channel's receive enable.
module timing_engine_fanout #(
   parameter int unsigned NUM_CH  = 3,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned DLY_EN  = 4,
   parameter int unsigned DLY_RX  = 2,
   parameter int unsigned STAGGER = 3,
   parameter int unsigned PLL_TO  = 10,
   parameter logic        ISO_VAL = 1'b0
) (
   input  logic              ck,
   input  logic              arst,
   input  logic              start,
   input  logic              stop,
   input  logic              tArstFs,
   input  logic              pllSettled,
   input  logic [NUM_CH-1:0] chEn,
   input  logic [NUM_CH-1:0] isolate,
   output logic [NUM_CH-1:0] radioEnable,
   output logic [NUM_CH-1:0] radioRxEn,
   output logic              busy,
   output logic              pllTimeout
);

   localparam longint unsigned CntMaxVal = (64'd1 << CNT_W) - 64'd1;
   localparam longint unsigned RxLast    = 64'(DLY_RX) + 64'(NUM_CH - 1) * 64'(STAGGER);

   // Every programmed delay must be representable by the shared counter.
   if (NUM_CH < 1 || NUM_CH > 16 || CNT_W < 1 || CNT_W > 32 || DLY_EN < 1 ||
       PLL_TO < 1 || 64'(PLL_TO) > CntMaxVal || 64'(DLY_EN) > CntMaxVal ||
       RxLast > CntMaxVal) begin : g_param_check
      $error("timing_engine_fanout: CNT_W too small or parameter out of range");
   end

   localparam logic [CNT_W-1:0] CntMax  = '1;
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
   localparam logic [CNT_W-1:0] PllLast = CNT_W'(PLL_TO - 1);
   localparam logic [CNT_W-1:0] EnLast  = CNT_W'(DLY_EN - 1);

   typedef enum logic [2:0] {
      StIdle,
      StWaitPll,
      StRamp,
      StEnabled,
      StActive
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] rx_q, rx_d;
   logic              to_q, to_d;

   logic [CNT_W-1:0]  cnt_sat;
   logic [NUM_CH-1:0] rx_due;
   logic [NUM_CH-1:0] rx_next;

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge ck or negedge arst) begin
      if (!arst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         mask_q  <= '0;
         en_q    <= '0;
         rx_q    <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         en_q    <= en_d;
         rx_q    <= rx_d;
         to_q    <= to_d;
      end
   end

   // Next-state logic: clear/abort first, then the power-up sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      en_d    = en_q;
      rx_d    = rx_q;
      to_d    = to_q;
      cnt_sat = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
      rx_due  = '0;
      // Channel i is due once the edge count since enable reaches its delay.
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (cnt_sat >= CNT_W'(DLY_RX + i * STAGGER)) begin
            rx_due[i] = 1'b1;
         end
      end
      rx_next = rx_q | (rx_due & mask_q);

      if (tArstFs) begin
         state_d = StIdle;
         cnt_d   = '0;
         en_d    = '0;
         rx_d    = '0;
         to_d    = 1'b0;
      end else if (stop) begin
         state_d = StIdle;
         cnt_d   = '0;
         en_d    = '0;
         rx_d    = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_d = StWaitPll;
                  mask_d  = chEn;
                  cnt_d   = '0;
               end
            end
            StWaitPll: begin
               if (pllSettled) begin
                  state_d = StRamp;
                  cnt_d   = '0;
               end else if (cnt_q >= PllLast) begin
                  state_d = StIdle;
                  cnt_d   = '0;
                  to_d    = 1'b1;
               end else begin
                  cnt_d = cnt_sat;
               end
            end
            StRamp: begin
               if (cnt_q >= EnLast) begin
                  cnt_d   = '0;
                  en_d    = mask_q;
                  state_d = (mask_q == '0) ? StActive : StEnabled;
               end else begin
                  cnt_d = cnt_sat;
               end
            end
            StEnabled: begin
               cnt_d = cnt_sat;
               rx_d  = rx_next;
               if ((rx_next & mask_q) == mask_q) begin
                  state_d = StActive;
               end
            end
            StActive: begin
               state_d = StActive;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // Isolation clamps the pins only; the registered state is untouched.
   assign radioEnable = (en_q & ~isolate) | ({NUM_CH{ISO_VAL}} & isolate);
   assign radioRxEn   = (rx_q & ~isolate) | ({NUM_CH{ISO_VAL}} & isolate);
   assign busy        = (state_q != StIdle);
   assign pllTimeout  = to_q;

endmodule

// File: tb/tb_timing_engine_fanout.sv
// Bench for timing_engine_fanout: directed scenarios plus random traffic,
// all compared against an event-time model of the power-up sequence.
module tb_timing_engine_fanout;

   localparam int NCH     = 3;
   localparam int DLY_EN  = 4;
   localparam int DLY_RX  = 2;
   localparam int STAGGER = 3;
   localparam int PLL_TO  = 10;
   localparam logic ISO_VAL = 1'b0;
   localparam int W = 2 * NCH + 2;

   logic ck;
   logic arst, start, stop, tArstFs, pllSettled;
   logic [NCH-1:0] chEn, isolate, radioEnable, radioRxEn;
   logic busy, pllTimeout;

   logic b_start, b_stop, b_tarst, b_pll;
   logic [0:0] b_chEn, b_iso, b_en, b_rx;
   logic b_busy, b_to;

   int total = 0;
   int bad = 0;

   timing_engine_fanout #(
      .NUM_CH(NCH), .CNT_W(8), .DLY_EN(DLY_EN), .DLY_RX(DLY_RX),
      .STAGGER(STAGGER), .PLL_TO(PLL_TO), .ISO_VAL(ISO_VAL)
   ) u_dut (
      .ck(ck), .arst(arst), .start(start), .stop(stop), .tArstFs(tArstFs),
      .pllSettled(pllSettled), .chEn(chEn), .isolate(isolate),
      .radioEnable(radioEnable), .radioRxEn(radioRxEn), .busy(busy),
      .pllTimeout(pllTimeout)
   );

   timing_engine_fanout #(
      .NUM_CH(1), .CNT_W(8), .DLY_EN(4), .DLY_RX(2),
      .STAGGER(0), .PLL_TO(10), .ISO_VAL(1'b0)
   ) u_dut1 (
      .ck(ck), .arst(arst), .start(b_start), .stop(b_stop), .tArstFs(b_tarst),
      .pllSettled(b_pll), .chEn(b_chEn), .isolate(b_iso),
      .radioEnable(b_en), .radioRxEn(b_rx), .busy(b_busy), .pllTimeout(b_to)
   );

   initial begin
      ck = 1'b0;
      forever #5 ck = ~ck;
   end

   // Model: edge index n, start/PLL-lock timestamps; outputs follow from them.
   int n = 0;
   int m_t0 = 0;
   int m_tp = 0;
   bit m_busy = 0, m_wait = 0, m_to = 0;
   logic [NCH-1:0] m_mask = '0;

   always @(posedge ck) begin
      n = n + 1;
      if (!arst) begin
         m_busy = 0; m_wait = 0; m_to = 0; m_mask = '0;
      end else if (tArstFs) begin
         m_busy = 0; m_wait = 0; m_to = 0;
      end else if (stop) begin
         m_busy = 0; m_wait = 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1; m_wait = 1; m_t0 = n; m_mask = chEn;
         end
      end else if (m_wait) begin
         if (pllSettled) begin
            m_wait = 0; m_tp = n;
         end else if (n - m_t0 >= PLL_TO) begin
            m_busy = 0; m_wait = 0; m_to = 1;
         end
      end
   end

   function automatic logic [W-1:0] exp_all();
      logic [NCH-1:0] e, r;
      e = '0;
      r = '0;
      for (int i = 0; i < NCH; i++) begin
         if (m_busy && !m_wait && m_mask[i] && n >= m_tp + DLY_EN) e[i] = 1'b1;
         if (m_busy && !m_wait && m_mask[i] && n >= m_tp + DLY_EN + DLY_RX + i * STAGGER)
            r[i] = 1'b1;
         if (isolate[i]) begin
            e[i] = ISO_VAL;
            r[i] = ISO_VAL;
         end
      end
      return {e, r, m_busy, m_to};
   endfunction

   task automatic test_reset();
      logic [W-1:0] g;
      #2;
      g = {radioEnable, radioRxEn, busy, pllTimeout};
      total++;
      if (g !== '0) begin bad++; $display("FAIL reset_async got=%b exp=0", g); end
      repeat (2) @(negedge ck);
      g = {radioEnable, radioRxEn, busy, pllTimeout};
      total++;
      if (g !== exp_all() || {b_en, b_rx, b_busy, b_to} !== 4'b0)
         begin bad++; $display("FAIL reset_hold got=%b b=%b exp=0", g, {b_en, b_rx, b_busy, b_to}); end
      arst = 1'b1;
   endtask

   task automatic test_nominal();
      logic [W-1:0] g, e;
      chEn = 3'b111;
      for (int k = 0; k <= 16; k++) begin
         start = (k == 0);
         pllSettled = (k >= 3 && k < 5);
         if (k == 1) chEn = 3'b000;
         @(negedge ck);
         g = {radioEnable, radioRxEn, busy, pllTimeout};
         e = exp_all();
         total++;
         if (g !== e) begin bad++; $display("FAIL nominal_model k=%0d got=%b exp=%b", k, g, e); end
         total++;
         if (radioEnable !== ((k >= 7) ? 3'b111 : 3'b000) ||
             radioRxEn !== {k >= 15, k >= 12, k >= 9} || busy !== 1'b1)
            begin bad++; $display("FAIL nominal_edge k=%0d en=%b rx=%b busy=%b", k, radioEnable, radioRxEn, busy); end
      end
      start = 0;
      pllSettled = 0;
   endtask

   task automatic test_isolation();
      logic [W-1:0] g, e;
      isolate = 3'b100;
      #1;
      total++;
      if (radioEnable !== 3'b011 || radioRxEn !== 3'b011)
         begin bad++; $display("FAIL iso_on en=%b rx=%b exp=011/011", radioEnable, radioRxEn); end
      @(negedge ck);
      g = {radioEnable, radioRxEn, busy, pllTimeout};
      e = exp_all();
      total++;
      if (g !== e) begin bad++; $display("FAIL iso_hold got=%b exp=%b", g, e); end
      isolate = 3'b000;
      #1;
      total++;
      if (radioEnable !== 3'b111 || radioRxEn !== 3'b111 || busy !== 1'b1)
         begin bad++; $display("FAIL iso_off en=%b rx=%b busy=%b exp=111/111/1", radioEnable, radioRxEn, busy); end
      @(negedge ck);
      stop = 1;
      @(negedge ck);
      stop = 0;
      g = {radioEnable, radioRxEn, busy, pllTimeout};
      total++;
      if (g !== exp_all() || g !== '0) begin bad++; $display("FAIL iso_stop got=%b exp=0", g); end
   endtask

   task automatic test_abort_restart();
      logic [W-1:0] g, e;
      chEn = 3'b111;
      for (int k = 0; k <= 11; k++) begin
         start = (k == 0);
         pllSettled = (k >= 3);
         stop = (k == 11);
         @(negedge ck);
         g = {radioEnable, radioRxEn, busy, pllTimeout};
         e = exp_all();
         total++;
         if (g !== e) begin bad++; $display("FAIL abort_model k=%0d got=%b exp=%b", k, g, e); end
      end
      total++;
      if ({radioEnable, radioRxEn, busy} !== 7'b0)
         begin bad++; $display("FAIL abort_clear en=%b rx=%b busy=%b exp=0", radioEnable, radioRxEn, busy); end
      stop = 0;
      pllSettled = 0;
      chEn = 3'b010;
      for (int k = 0; k <= 13; k++) begin
         start = (k == 0);
         pllSettled = (k >= 3);
         @(negedge ck);
         g = {radioEnable, radioRxEn, busy, pllTimeout};
         e = exp_all();
         total++;
         if (g !== e) begin bad++; $display("FAIL restart_model k=%0d got=%b exp=%b", k, g, e); end
         total++;
         if (radioEnable !== ((k >= 7) ? 3'b010 : 3'b000) ||
             radioRxEn !== ((k >= 12) ? 3'b010 : 3'b000))
            begin bad++; $display("FAIL restart_edge k=%0d en=%b rx=%b", k, radioEnable, radioRxEn); end
      end
      start = 0;
      pllSettled = 0;
      stop = 1;
      @(negedge ck);
      stop = 0;
   endtask

   task automatic test_timeout();
      logic [W-1:0] g, e;
      chEn = 3'b111;
      pllSettled = 0;
      for (int k = 0; k <= 10; k++) begin
         start = (k == 0);
         @(negedge ck);
         g = {radioEnable, radioRxEn, busy, pllTimeout};
         e = exp_all();
         total++;
         if (g !== e) begin bad++; $display("FAIL timeout_model k=%0d got=%b exp=%b", k, g, e); end
         total++;
         if (busy !== (k < 10) || pllTimeout !== (k >= 10))
            begin bad++; $display("FAIL timeout_edge k=%0d busy=%b to=%b", k, busy, pllTimeout); end
      end
      start = 1;
      @(negedge ck);
      start = 0;
      total++;
      if (busy !== 1'b1 || pllTimeout !== 1'b1 || {busy, pllTimeout} !== {m_busy, m_to})
         begin bad++; $display("FAIL timeout_restart busy=%b to=%b exp=1/1", busy, pllTimeout); end
      tArstFs = 1;
      @(negedge ck);
      tArstFs = 0;
      total++;
      if (busy !== 1'b0 || pllTimeout !== 1'b0)
         begin bad++; $display("FAIL timeout_clear busy=%b to=%b exp=0/0", busy, pllTimeout); end
   endtask

   task automatic test_simultaneous();
      logic [W-1:0] g, e;
      start = 1; stop = 1;
      @(negedge ck);
      start = 0; stop = 0;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL start_stop busy=%b exp=0", busy); end
      start = 1; tArstFs = 1;
      @(negedge ck);
      start = 0; tArstFs = 0;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL start_tarst busy=%b exp=0", busy); end
      chEn = 3'b101;
      for (int k = 0; k <= 11; k++) begin
         start = (k <= 8);
         pllSettled = (k >= 3);
         @(negedge ck);
         g = {radioEnable, radioRxEn, busy, pllTimeout};
         e = exp_all();
         total++;
         if (g !== e) begin bad++; $display("FAIL ramp_start_model k=%0d got=%b exp=%b", k, g, e); end
         total++;
         if (radioEnable !== ((k >= 7) ? 3'b101 : 3'b000))
            begin bad++; $display("FAIL ramp_start_edge k=%0d en=%b", k, radioEnable); end
      end
      start = 0;
      pllSettled = 0;
      stop = 1;
      @(negedge ck);
      stop = 0;
   endtask

   task automatic test_async_reset();
      logic [W-1:0] g, e;
      chEn = 3'b111;
      for (int k = 0; k <= 8; k++) begin
         start = (k == 0);
         pllSettled = (k >= 3);
         @(negedge ck);
         g = {radioEnable, radioRxEn, busy, pllTimeout};
         e = exp_all();
         total++;
         if (g !== e) begin bad++; $display("FAIL async_pre k=%0d got=%b exp=%b", k, g, e); end
      end
      start = 0;
      pllSettled = 0;
      #2 arst = 0;
      #1;
      g = {radioEnable, radioRxEn, busy, pllTimeout};
      total++;
      if (g !== '0) begin bad++; $display("FAIL async_clear got=%b exp=0", g); end
      @(negedge ck);
      arst = 1;
      start = 1;
      chEn = 3'b011;
      @(negedge ck);
      start = 0;
      g = {radioEnable, radioRxEn, busy, pllTimeout};
      e = exp_all();
      total++;
      if (g !== e || busy !== 1'b1)
         begin bad++; $display("FAIL async_first_start got=%b exp=%b", g, e); end
      stop = 1;
      @(negedge ck);
      stop = 0;
   endtask

   task automatic test_single_ch();
      b_chEn = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         b_start = (k == 0);
         b_pll = (k >= 3);
         @(negedge ck);
         total++;
         if (b_en !== 1'(k >= 7) || b_rx !== 1'(k >= 9) || b_busy !== 1'b1)
            begin bad++; $display("FAIL single_ch k=%0d en=%b rx=%b busy=%b", k, b_en, b_rx, b_busy); end
      end
      b_start = 0;
      b_pll = 0;
      b_stop = 1;
      @(negedge ck);
      b_stop = 0;
      total++;
      if ({b_en, b_rx, b_busy} !== 3'b000)
         begin bad++; $display("FAIL single_ch_stop en=%b rx=%b busy=%b exp=0", b_en, b_rx, b_busy); end
   endtask

   task automatic test_random();
      logic [W-1:0] g, e;
      int pll_pct;
      for (int c = 0; c < 600; c++) begin
         pll_pct = ((c / 100) % 2 == 1) ? 30 : 6;
         start = ($urandom_range(0, 99) < 30);
         stop = ($urandom_range(0, 99) < 4);
         tArstFs = ($urandom_range(0, 99) < 2);
         pllSettled = ($urandom_range(0, 99) < pll_pct);
         chEn = 3'($urandom);
         isolate = ($urandom_range(0, 99) < 20) ? 3'($urandom) : 3'b000;
         @(negedge ck);
         g = {radioEnable, radioRxEn, busy, pllTimeout};
         e = exp_all();
         total++;
         if (g !== e) begin bad++; $display("FAIL random c=%0d got=%b exp=%b", c, g, e); end
      end
      start = 0; stop = 0; tArstFs = 0; pllSettled = 0; isolate = '0;
   endtask

   initial begin
      arst = 0; start = 0; stop = 0; tArstFs = 0; pllSettled = 0;
      chEn = '0; isolate = '0;
      b_start = 0; b_stop = 0; b_tarst = 0; b_pll = 0; b_chEn = '0; b_iso = '0;
      test_reset();
      test_nominal();
      test_isolation();
      test_abort_restart();
      test_timeout();
      test_simultaneous();
      test_async_reset();
      test_single_ch();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timing_engine_fanout.md
TIMING_ENGINE_FANOUT -- requirements
Module: timing_engine_fanout

Parameters
REQ-001 The block SHALL have parameter NUM_CH, default 3: number of radio channels driven (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the shared cycle counter.
REQ-003 The block SHALL have parameter DLY_EN, default 4: cycles from PLL settled to radioEnable (1..2^CNT_W-1).
REQ-004 The block SHALL have parameter DLY_RX, default 2: cycles from radioEnable to channel 0 radioRxEn.
REQ-005 The block SHALL have parameter STAGGER, default 3: extra cycles of radioRxEn delay per channel index.
REQ-006 The block SHALL have parameter PLL_TO, default 10: maximum cycles spent waiting for pllSettled.
REQ-007 The block SHALL have parameter ISO_VAL, default 1'b0: clamp value driven on isolated channel outputs.

Interface
REQ-008 The block SHALL have port ck, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-009 The block SHALL have port arst, input, 1 bit: asynchronous reset, active-low.
REQ-010 The block SHALL have port start, input, 1 bit: request a power-up sequence.
REQ-011 The block SHALL have port stop, input, 1 bit: abort or terminate the sequence.
REQ-012 The block SHALL have port tArstFs, input, 1 bit: synchronous timing-engine clear.
REQ-013 The block SHALL have port pllSettled, input, 1 bit: PLL lock indication.
REQ-014 The block SHALL have port chEn, input, NUM_CH bits: channel enable mask, latched at start.
REQ-015 The block SHALL have port isolate, input, NUM_CH bits: per-channel output isolation.
REQ-016 The block SHALL have port radioEnable, output, NUM_CH bits: per-channel radio enable.
REQ-017 The block SHALL have port radioRxEn, output, NUM_CH bits: per-channel receive enable.
REQ-018 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-019 The block SHALL have port pllTimeout, output, 1 bit: sticky PLL timeout error flag.

Function
REQ-020 The FSM SHALL have states IDLE, WAIT_PLL, RAMP, ENABLED and ACTIVE.
REQ-021 From IDLE, start=1 with stop=0 and tArstFs=0 SHALL move the FSM to WAIT_PLL on that edge, latch chEn into chMask and clear the counter.
REQ-022 In WAIT_PLL, pllSettled=1 sampled SHALL move the FSM to RAMP with the counter cleared.
REQ-023 In WAIT_PLL, if the counter reaches PLL_TO-1 with pllSettled=0, the FSM SHALL go to IDLE and set pllTimeout.
REQ-024 In RAMP, the FSM SHALL move to ENABLED after exactly DLY_EN edges, so radioEnable rises DLY_EN edges after the edge on which pllSettled was sampled high.
REQ-025 On entry to ENABLED, radioEnable[i] SHALL be set for every i with chMask[i]=1, and the counter SHALL clear.
REQ-026 In ENABLED, radioRxEn[i] SHALL assert DLY_RX + i*STAGGER edges after radioEnable rose, for each channel with chMask[i]=1.
REQ-027 The FSM SHALL enter ACTIVE on the edge at which the highest-index masked channel asserts radioRxEn; with chMask all zero, it SHALL enter ACTIVE directly from RAMP.
REQ-028 In ACTIVE, the FSM SHALL hold all outputs until stop or tArstFs.
REQ-029 In any non-IDLE state, stop=1 SHALL clear all radioEnable/radioRxEn registers and move the FSM to IDLE on the next edge.
REQ-030 tArstFs=1 SHALL act as stop in every state and SHALL additionally clear pllTimeout; tArstFs takes priority over start and stop.
REQ-031 When start and stop are high together in IDLE, the FSM SHALL stay in IDLE.
REQ-032 start while busy=1 SHALL be ignored, and chEn changes after latching SHALL have no effect.
REQ-033 pllSettled falling after WAIT_PLL SHALL be ignored.
REQ-034 The counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-035 CNT_W SHALL be large enough to hold PLL_TO, DLY_EN and DLY_RX + (NUM_CH-1)*STAGGER; an elaboration-time check SHALL enforce this.
REQ-036 Isolation SHALL be combinational on the registered outputs: isolate[i]=1 forces radioEnable[i] and radioRxEn[i] to ISO_VAL without altering internal state.
REQ-037 Deasserting isolate[i] SHALL restore the internal value of channel i in the same cycle.
REQ-038 pllTimeout SHALL remain set until tArstFs or reset; a new start while pllTimeout=1 is allowed.

Reset
REQ-039 While arst=0, the block SHALL asynchronously force state IDLE, counter 0, chMask 0, radioEnable 0, radioRxEn 0, busy 0 and pllTimeout 0.
REQ-040 Reset release SHALL be synchronous to ck, and the first start SHALL be honoured on the first edge after release.
REQ-041 Reset asserted mid-sequence SHALL clear all outputs immediately without waiting for a clock edge.

Verification (defaults unless noted)
REQ-042 The bench SHALL cover nominal sequencing: chEn=3'b111, start at edge 0, pllSettled=1 from edge 3 -> radioEnable=3'b111 at edge 7, radioRxEn[0] at edge 9, [1] at 12, [2] at 15, ACTIVE at 15.
REQ-043 The bench SHALL cover PLL timeout: start, pllSettled held 0 -> pllTimeout=1 and busy=0 ten edges after WAIT_PLL entry; tArstFs pulse -> pllTimeout=0.
REQ-044 The bench SHALL cover abort and restart: stop at edge 10 of the nominal sequence -> all outputs 0 and IDLE at edge 11; a new start with chEn=3'b010 -> only channel 1 sequences, radioRxEn[1] 5 edges after radioEnable.
REQ-045 The bench SHALL cover isolation: isolate=3'b100 in ACTIVE -> outputs read 3'b011 on both buses; releasing isolate -> 3'b111 in the same cycle, with no state change.
REQ-046 The bench SHALL cover simultaneous events: start+stop in IDLE -> stays IDLE; start+tArstFs in IDLE -> stays IDLE; start during RAMP -> timing unchanged.
REQ-047 The bench SHALL cover asynchronous reset: arst=0 mid-ENABLED between edges -> all outputs 0 before the next edge; with NUM_CH=1 and STAGGER=0 the nominal timing holds for channel 0.
